// File: rtl/uart_pkg.sv
//============================================================================
// Module : uart_pkg
// Shared UART receiver state encodings and bit-timing derivation.
// Rev    : 1.0
//============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_t;

    // Transmitter and receiver both call these so their bit timing matches.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int half_bit(input int clk_freq, input int baud);
        return clks_per_bit(clk_freq, baud) / 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
//============================================================================
// Module : sync_2ff
// Generic two-flop synchronizer with a configurable reset value.
// Rev    : 1.0
//============================================================================
`default_nettype none

module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
//============================================================================
// Module : uart_rx
// 8N1 UART receiver with start/stop validation and a one-byte holding register.
// Rev    : 1.0
//============================================================================
`default_nettype none

module uart_rx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o
);

    import uart_pkg::*;

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF_BIT     = half_bit(CLK_FREQ, BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

    // Fewer than four clocks per bit leaves no room for a mid-bit sample.
    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_baud
            $error("uart_rx: CLK_FREQ / BAUD must be at least 4");
        end
    endgenerate

    logic             rx_s;
    rx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic             byte_done;
    logic             stop_err;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk_i),
        .rst (rst_i),
        .d   (rx_i),
        .q   (rx_s)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        byte_done = 1'b0;
        stop_err  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_n = ST_START;
                    cnt_n   = '0;
                end
            end

            ST_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n = '0;
                    // A start bit that is gone by mid-bit was only a glitch.
                    if (!rx_s) begin
                        state_n   = ST_DATA;
                        bit_idx_n = '0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            ST_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n     = '0;
                    shreg_n   = {rx_s, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = ST_STOP;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            ST_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        byte_done = 1'b1;
                        state_n   = ST_IDLE;
                    end else begin
                        stop_err = 1'b1;
                        state_n  = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            // A held-low line (break) must not look like a fresh start bit.
            ST_WAIT_HIGH: begin
                if (rx_s) begin
                    state_n = ST_IDLE;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o      <= 8'h00;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= stop_err;
            overrun_o   <= 1'b0;
            if (byte_done) begin
                // Slot is free if empty or being drained this very cycle.
                if (!valid_o || ready_i) begin
                    data_o  <= shreg;
                    valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
//============================================================================
// Module : tb_uart_rx
// Self-checking bench for uart_rx driven by a behavioural serial transmitter.
// Rev    : 1.0
//============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       rx_i = 1'b1;
    logic       ready_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         fe_cnt   = 0;
    int         ov_cnt   = 0;
    int         stab_err = 0;
    logic       prev_valid = 1'b0;
    logic       prev_hs    = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    uart_rx #(
        .CLK_FREQ (16),
        .BAUD     (1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk = ~clk;

    // Consumer-side observer: accepted bytes, status pulses, data stability.
    always @(negedge clk) begin
        if (rst_i) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_valid && !prev_hs && valid_o && (data_o !== prev_data))
                stab_err++;
            if (valid_o && ready_i) rx_q.push_back(data_o);
            if (frame_err_o) fe_cnt++;
            if (overrun_o) ov_cnt++;
            prev_valid = valid_o;
            prev_hs    = valid_o && ready_i;
            prev_data  = data_o;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rx_q.delete();
        fe_cnt = 0;
        ov_cnt = 0;
    endtask

    // Serial 8N1 transmitter; the line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx_i = 1'b0;
        idle(CPB);
        for (int k = 0; k < 8; k++) begin
            rx_i = b[k];
            idle(CPB);
        end
        rx_i = stop_bit;
        idle(CPB);
    endtask

    task automatic check_one_byte(input string name, input logic [7:0] exp);
        logic [7:0] got;
        checks++;
        if (rx_q.size() != 1) begin
            failures++;
            $display("FAIL %s_count: got %0d bytes, want 1", name, rx_q.size());
        end
        got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s_data: got %h want %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_i   = 1'b1;
        rx_i    = 1'b1;
        ready_i = 1'b0;
        idle(3);
        @(negedge clk);
        checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", data_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        checks++; if (frame_err_o !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %b want 0", frame_err_o); end
        checks++; if (overrun_o !== 1'b0) begin failures++; $display("FAIL reset_ovr: got %b want 0", overrun_o); end
        @(posedge clk);
        #1 rst_i = 1'b0;
        clear_mon();
        idle(20);
        checks++; if (rx_q.size() != 0 || valid_o !== 1'b0) begin failures++; $display("FAIL idle_quiet: got %0d bytes valid=%b want 0", rx_q.size(), valid_o); end
    endtask

    task automatic test_single_byte();
        ready_i = 1'b1;
        clear_mon();
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (154) @(posedge clk);
                @(negedge clk);
                checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL single_early: valid got %b want 0 at T0+152", valid_o); end
                @(posedge clk);
                @(negedge clk);
                checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL single_valid: got %b want 1 at T0+153", valid_o); end
                checks++; if (data_o !== 8'hA5) begin failures++; $display("FAIL single_data: got %h want a5", data_o); end
                @(posedge clk);
                @(negedge clk);
                checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL single_drop: valid got %b want 0", valid_o); end
            end
        join
        idle(4);
        check_one_byte("single", 8'hA5);
        checks++; if (fe_cnt != 0 || ov_cnt != 0) begin failures++; $display("FAIL single_status: got ferr=%0d ovr=%0d want 0", fe_cnt, ov_cnt); end
    endtask

    task automatic test_glitch();
        ready_i = 1'b1;
        clear_mon();
        rx_i = 1'b0;
        idle(4);
        rx_i = 1'b1;
        idle(20);
        checks++; if (rx_q.size() != 0 || valid_o !== 1'b0) begin failures++; $display("FAIL glitch_valid: got %0d bytes want 0", rx_q.size()); end
        send_frame(8'h3C, 1'b1);
        idle(4);
        check_one_byte("glitch_next", 8'h3C);
        checks++; if (fe_cnt != 0) begin failures++; $display("FAIL glitch_ferr: got %0d want 0", fe_cnt); end
    endtask

    task automatic test_frame_err();
        ready_i = 1'b1;
        clear_mon();
        fork
            send_frame(8'h5A, 1'b0);
            begin
                repeat (155) @(posedge clk);
                @(negedge clk);
                checks++; if (frame_err_o !== 1'b1) begin failures++; $display("FAIL ferr_pulse: got %b want 1 at T0+153", frame_err_o); end
            end
        join
        idle(40);
        checks++; if (fe_cnt != 1) begin failures++; $display("FAIL ferr_count: got %0d want 1", fe_cnt); end
        checks++; if (rx_q.size() != 0 || valid_o !== 1'b0) begin failures++; $display("FAIL ferr_novalid: got %0d bytes want 0", rx_q.size()); end
        rx_i = 1'b1;
        idle(16);
        send_frame(8'h3C, 1'b1);
        idle(4);
        check_one_byte("ferr_next", 8'h3C);
        checks++; if (fe_cnt != 1) begin failures++; $display("FAIL ferr_after: got %0d pulses want 1", fe_cnt); end
    endtask

    task automatic test_overrun();
        ready_i = 1'b0;
        clear_mon();
        send_frame(8'h01, 1'b1);
        @(negedge clk);
        checks++; if (valid_o !== 1'b1 || data_o !== 8'h01) begin failures++; $display("FAIL ovr_first: got valid=%b data=%h want 1/01", valid_o, data_o); end
        #1;
        send_frame(8'h80, 1'b1);
        idle(2);
        checks++; if (ov_cnt != 1) begin failures++; $display("FAIL ovr_pulse: got %0d want 1", ov_cnt); end
        checks++; if (data_o !== 8'h01 || valid_o !== 1'b1) begin failures++; $display("FAIL ovr_hold: got valid=%b data=%h want 1/01", valid_o, data_o); end
        ready_i = 1'b1;
        idle(1);
        ready_i = 1'b0;
        @(negedge clk);
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL ovr_drain: valid got %b want 0", valid_o); end
        #1;
        check_one_byte("ovr", 8'h01);
    endtask

    task automatic test_simultaneous();
        ready_i = 1'b0;
        clear_mon();
        send_frame(8'h11, 1'b1);
        idle(2);
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1 ready_i = 1'b1;
                @(posedge clk);
                #1 ready_i = 1'b0;
                @(negedge clk);
                checks++; if (valid_o !== 1'b1 || data_o !== 8'h22) begin failures++; $display("FAIL simul_load: got valid=%b data=%h want 1/22", valid_o, data_o); end
            end
        join
        checks++; if (ov_cnt != 0) begin failures++; $display("FAIL simul_ovr: got %0d want 0", ov_cnt); end
        check_one_byte("simul_first", 8'h11);
        ready_i = 1'b1;
        idle(2);
        ready_i = 1'b0;
        checks++; if (rx_q.size() != 2 || rx_q[rx_q.size()-1] !== 8'h22) begin failures++; $display("FAIL simul_second: got %0d bytes want 2 ending 22", rx_q.size()); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        ready_i = 1'b0;
        clear_mon();
        send_frame(8'h5E, 1'b1);
        idle(2);
        checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL midrst_setup: valid got %b want 1", valid_o); end
        // Upper nibble all ones keeps the line high after the interrupted bit 4.
        b = {4'hF, 4'($urandom_range(0, 15))};
        fork
            send_frame(b, 1'b1);
            begin
                repeat (87) @(posedge clk);
                #1 rst_i = 1'b1;
                @(posedge clk);
                #1 rst_i = 1'b0;
                @(negedge clk);
                checks++; if (valid_o !== 1'b0 || data_o !== 8'h00) begin failures++; $display("FAIL midrst_out: got valid=%b data=%h want 0/00", valid_o, data_o); end
                checks++; if (frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin failures++; $display("FAIL midrst_status: got ferr=%b ovr=%b want 0", frame_err_o, overrun_o); end
            end
        join
        ready_i = 1'b1;
        idle(4);
        checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL midrst_flush: got %0d bytes want 0", rx_q.size()); end
        send_frame(8'hC3, 1'b1);
        idle(4);
        check_one_byte("midrst_next", 8'hC3);
        checks++; if (fe_cnt != 0 || ov_cnt != 0) begin failures++; $display("FAIL midrst_flags: got ferr=%0d ovr=%0d want 0", fe_cnt, ov_cnt); end
    endtask

    task automatic test_random_stream();
        logic [7:0] b;
        logic [7:0] got;
        int         bad;
        ready_i = 1'b1;
        clear_mon();
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            idle($urandom_range(0, 6));
        end
        idle(8);
        checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            checks++;
            if (got !== exp_q[i]) begin
                failures++;
                if (bad < 8) $display("FAIL rand_byte[%0d]: got %h want %h", i, got, exp_q[i]);
                bad++;
            end
        end
        checks++; if (fe_cnt != 0 || ov_cnt != 0) begin failures++; $display("FAIL rand_status: got ferr=%0d ovr=%0d want 0", fe_cnt, ov_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_simultaneous();
        test_reset_midframe();
        test_random_stream();
        checks++;
        if (stab_err != 0) begin
            failures++;
            $display("FAIL data_stable: got %0d changes while valid want 0", stab_err);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
